// File: rtl/edge_event_encoder.sv
// Round-robin encoder: turns a sticky edge vector into one event index per handshake.
// Latency: one cycle from a new edge bit to evt_valid_o; back-to-back accepts have no bubble.
// Backpressure: a presented event holds its index until accepted, even if its edge bit drops.
module edge_event_encoder #(
    parameter int WIDTH = 32,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] edge_i,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [IDXW-1:0]  evt_idx_o,
    output logic [IDXW:0]    pending_o
);

    logic             r_valid;
    logic [IDXW-1:0]  r_idx;
    logic [IDXW-1:0]  r_ptr;
    logic [WIDTH-1:0] r_seen;
    logic [IDXW:0]    r_pending;

    logic             w_accept;
    logic             w_load;
    logic [WIDTH-1:0] w_acc_onehot;
    logic [WIDTH-1:0] w_cur_onehot;
    logic [WIDTH-1:0] w_seen_next;
    logic [WIDTH-1:0] w_pend;
    logic [WIDTH-1:0] w_unrep;
    logic             w_found;
    logic [IDXW-1:0]  w_sel;
    logic [IDXW:0]    w_count;

    assign w_accept     = r_valid & evt_ready_i;
    assign w_load       = ~r_valid | w_accept;
    assign w_acc_onehot = w_accept ? (WIDTH'(1) << r_idx) : '0;
    assign w_cur_onehot = r_valid  ? (WIDTH'(1) << r_idx) : '0;

    // Masking with edge_i lets a bit that was cleared upstream re-arm.
    assign w_seen_next  = (r_seen | w_acc_onehot) & edge_i;
    assign w_pend       = edge_i & ~r_seen & ~w_cur_onehot;
    assign w_unrep      = edge_i & ~w_seen_next;

    // First pending bit at or above the pointer, wrapping at WIDTH-1.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!w_found && w_pend[r_ptr + IDXW'(i)]) begin
                w_found = 1'b1;
                w_sel   = r_ptr + IDXW'(i);
            end
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_count = w_count + (IDXW+1)'(w_unrep[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_seen    <= '0;
            r_pending <= '0;
        end else begin
            r_seen    <= w_seen_next;
            r_pending <= w_count;
            if (w_accept) begin
                r_ptr <= r_idx + IDXW'(1);
            end
            if (w_load) begin
                r_valid <= w_found;
                if (w_found) begin
                    r_idx <= w_sel;
                end
            end
        end
    end

    assign evt_valid_o = r_valid;
    assign evt_idx_o   = r_idx;
    assign pending_o   = r_pending;

endmodule

// File: tb/tb_edge_event_encoder.sv
// Scoreboard bench for edge_event_encoder: stimulus queues expected events, a monitor pops on handshake.
module tb_edge_event_encoder;

    logic        clk;
    logic        reset;
    logic [31:0] edge_i;
    logic        evt_valid_o;
    logic        evt_ready_i;
    logic [4:0]  evt_idx_o;
    logic [5:0]  pending_o;

    typedef struct {
        logic [4:0] idx;
        logic [5:0] pend;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    edge_event_encoder #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .edge_i      (edge_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_idx_o   (evt_idx_o),
        .pending_o   (pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    endtask

    task automatic push(input int idx, input int pend);
        exp_t e;
        e.idx  = 5'(idx);
        e.pend = 6'(pend);
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake must match the next expected event.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && evt_valid_o === 1'b1 && evt_ready_i === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: got idx %0d, expected no event", evt_idx_o);
            end else begin
                e = sb_q.pop_front();
                check("evt_idx", 32'(evt_idx_o), 32'(e.idx));
                check("evt_pending", 32'(pending_o), 32'(e.pend));
            end
        end
    end

    initial begin
        reset       = 1'b1;
        edge_i      = 32'h0000_00FF;
        evt_ready_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_valid", 32'(evt_valid_o), 0);
            check("rst_idx", 32'(evt_idx_o), 0);
            check("rst_pending", 32'(pending_o), 0);
        end

        // Ordering: 2 then 5
        reset       = 1'b0;
        edge_i      = 32'h0000_0024;
        evt_ready_i = 1'b1;
        push(2, 2);
        push(5, 1);
        tick(); tick(); tick();
        check("ord_idle_valid", 32'(evt_valid_o), 0);
        check("ord_idle_pending", 32'(pending_o), 0);

        // Round-robin from pointer 6: 7 then 1
        edge_i = 32'h0000_00A6;
        push(7, 2);
        push(1, 1);
        tick(); tick(); tick();
        check("rr_idle_valid", 32'(evt_valid_o), 0);

        // Backpressure: index 0 held stable
        evt_ready_i = 1'b0;
        edge_i      = 32'h0000_0001;
        push(0, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_valid", 32'(evt_valid_o), 1);
            check("bp_idx", 32'(evt_idx_o), 0);
        end
        evt_ready_i = 1'b1;
        tick();
        check("bp_done_valid", 32'(evt_valid_o), 0);
        tick();
        check("bp_norepeat_valid", 32'(evt_valid_o), 0);

        // Re-arm: bit 3 reported twice around a one-cycle drop
        edge_i = 32'h0000_0008;
        push(3, 1);
        tick(); tick();
        check("rearm_first_idle", 32'(evt_valid_o), 0);
        edge_i = 32'h0000_0000;
        tick();
        check("rearm_gap_valid", 32'(evt_valid_o), 0);
        edge_i = 32'h0000_0008;
        push(3, 1);
        tick(); tick();
        check("rearm_second_idle", 32'(evt_valid_o), 0);

        // Full vector from a fresh reset: 0..31 in order
        reset = 1'b1;
        tick();
        check("rst2_valid", 32'(evt_valid_o), 0);
        reset  = 1'b0;
        edge_i = 32'hFFFF_FFFF;
        for (int k = 0; k < 32; k++) push(k, 32 - k);
        tick();
        check("full_first_pending", 32'(pending_o), 32);
        repeat (32) tick();
        check("full_idle_valid", 32'(evt_valid_o), 0);
        check("full_idle_pending", 32'(pending_o), 0);

        // Pointer wrapped to 0: restart, then reset mid-stream at index 10
        edge_i = 32'h0000_0000;
        tick();
        edge_i = 32'hFFFF_FFFF;
        for (int k = 0; k < 10; k++) push(k, 32 - k);
        repeat (11) tick();
        check("mid_idx", 32'(evt_idx_o), 10);
        check("mid_valid", 32'(evt_valid_o), 1);
        reset = 1'b1;
        tick();
        check("mid_rst_valid", 32'(evt_valid_o), 0);
        check("mid_rst_idx", 32'(evt_idx_o), 0);
        check("mid_rst_pending", 32'(pending_o), 0);
        reset  = 1'b0;
        edge_i = 32'h0000_0000;
        tick(); tick();
        check("post_valid", 32'(evt_valid_o), 0);
        check("sb_empty", 32'(sb_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/edge_event_encoder.md
EDGE_EVENT_ENCODER -- requirements
Module: edge_event_encoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the number of edge bits; legal values are powers of two, 2..32.
REQ-002 The block SHALL have derived parameter IDXW = clog2(WIDTH), default 5, meaning the event index width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port edge_i, input, WIDTH bits: sticky captured-edge vector from the upstream edge_capture stage (edge_o).
REQ-006 The block SHALL have port evt_valid_o, output, 1 bit: an event index is presented.
REQ-007 The block SHALL have port evt_ready_i, input, 1 bit: the consumer accepts the presented event.
REQ-008 The block SHALL have port evt_idx_o, output, IDXW bits: bit position of the presented event.
REQ-009 The block SHALL have port pending_o, output, IDXW+1 bits: registered count of set-but-unreported bits.

Function
REQ-010 The block SHALL keep an internal WIDTH-bit reported mask seen_q, where a set bit means the edge was already delivered.
REQ-011 The block SHALL define the pending set as edge_i & ~seen_q, excluding the bit currently presented on evt_idx_o while evt_valid_o=1.
REQ-012 An event SHALL be accepted on a clock edge where evt_valid_o=1 and evt_ready_i=1.
REQ-013 The block SHALL update seen_q as seen_q_next = (seen_q | accept_onehot) & edge_i, so a bit cleared upstream re-arms.
REQ-014 On an edge where evt_valid_o=0, or an accept occurs, and the pending set is non-empty, the block SHALL register evt_valid_o=1 and evt_idx_o=the selected bit.
REQ-015 On an edge where evt_valid_o=0, or an accept occurs, and the pending set is empty, evt_valid_o SHALL go 0.
REQ-016 Selection SHALL be round-robin: choose the first pending bit at or above pointer ptr_q, wrapping from WIDTH-1 to 0.
REQ-017 On each accept of index k, ptr_q SHALL become (k+1) mod WIDTH; ptr_q SHALL be unchanged otherwise.
REQ-018 Latency SHALL be one cycle: a bit that first appears in edge_i before edge N, with the output idle, gives evt_valid_o=1 after edge N.
REQ-019 With evt_ready_i held high, back-to-back accepts SHALL yield one event per cycle with no bubble.
REQ-020 While evt_valid_o=1 and evt_ready_i=0, evt_valid_o and evt_idx_o SHALL hold stable, even if that edge_i bit drops.
REQ-021 An event accepted after its edge_i bit dropped SHALL complete normally; per REQ-013, seen_q is not left set for it.
REQ-022 Each set edge_i bit SHALL be reported exactly once per 0->1 rising of that bit.
REQ-023 pending_o SHALL register, each cycle, popcount(edge_i & ~seen_q) including the presented bit; range 0..WIDTH.
REQ-024 If all WIDTH bits are pending, pending_o SHALL equal WIDTH with no overflow.
REQ-025 The block SHALL not use the evt_ready_i value when evt_valid_o=0.

Reset
REQ-026 While reset=1 at a clock edge, the block SHALL set evt_valid_o=0, evt_idx_o=0, pending_o=0, seen_q=0 and ptr_q=0.
REQ-027 Reset SHALL override a simultaneous accept and abort any presented event without setting seen_q.
REQ-028 In the first cycle after reset deasserts, edge_i bits that are already set SHALL be treated as new and reported per REQ-014..REQ-018.

Verification
REQ-029 Reset check: reset=1 for 2 cycles, edge_i=0x0000_00FF -> evt_valid_o=0, evt_idx_o=0, pending_o=0 throughout.
REQ-030 Ordering check: edge_i=0x0000_0024, evt_ready_i=1 -> indices 2 then 5 on consecutive cycles, then evt_valid_o=0, pending_o 2,1,0.
REQ-031 Round-robin check: after the REQ-030 sequence (ptr=6), set edge_i=0x0000_00A6 -> indices 7, 1 (2 and 5 are not re-reported), then idle.
REQ-032 Backpressure check: edge_i=0x0000_0001 with evt_ready_i=0 for 3 cycles -> evt_valid_o=1 and evt_idx_o=0 stable; the event is accepted once when ready=1; no repeat.
REQ-033 Re-arm check: bit 3 reported, then edge_i bit 3 cleared for 1 cycle and set again -> index 3 is reported a second time.
REQ-034 Wrap and full check: edge_i=0xFFFF_FFFF, ready=1 -> indices 0..31 in order, pending_o starts at 32; a reset asserted mid-stream (at index 10) gives evt_valid_o=0 on the next edge.
